// File: rtl/bm_input_controller_if.sv
// Button-to-movement bundle between the board button pins and the game logic.
// The master side drives raw buttons and gameover and reads the movement
// controls. The slave side is the input controller.
interface bm_input_controller_if;
    logic       btn_u;
    logic       btn_r;
    logic       btn_d;
    logic       btn_l;
    logic       btn_bomb;
    logic       gameover;
    logic       U;
    logic       R;
    logic       D;
    logic       L;
    logic [1:0] current_dir;
    logic       bomb_req;

    modport master (
        output btn_u, btn_r, btn_d, btn_l, btn_bomb, gameover,
        input  U, R, D, L, current_dir, bomb_req
    );

    modport slave (
        input  btn_u, btn_r, btn_d, btn_l, btn_bomb, gameover,
        output U, R, D, L, current_dir, bomb_req
    );
endinterface

// File: rtl/bm_input_controller.sv
// Push-button front end for the bomberman block.
// Each raw button is passed through a 2-flop synchroniser and a counter
// debouncer. A two-state FSM then tracks the most recently pressed held
// direction and produces registered one-hot move requests plus current_dir.
// A press of the bomb button produces a single-cycle bomb_req.
// gameover freezes direction state and silences the outputs, while the
// debouncers keep tracking the buttons.
module bm_input_controller #(
    parameter int DB_CNT = 1000000
) (
    input logic                  clk,
    input logic                  reset,
    bm_input_controller_if.slave bus
);

    localparam int NB    = 5;
    localparam int CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit order: 0=up, 1=right, 2=down, 3=left, 4=bomb. Direction bits 0..3
    // match the current_dir encoding and the U > R > D > L priority.
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] db;
    logic [NB-1:0] rise;

    assign btn_raw = {bus.btn_bomb, bus.btn_l, bus.btn_d, bus.btn_r, bus.btn_u};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi = gi + 1) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             db_reg;
            logic             db_d_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Synchronise, then accept a new level only after it has
            // disagreed with the stable level for DB_CNT consecutive cycles.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    db_d_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    db_d_reg  <= db_reg;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= ~db_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign db[gi]   = db_reg;
            assign rise[gi] = db_reg & ~db_d_reg;
        end
    endgenerate

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] dir_reg;
    logic [1:0] dir_next;
    logic [3:0] move_reg;
    logic       bomb_req_reg;
    logic       rise_any;
    logic       held_any;
    logic [1:0] rise_sel;
    logic [1:0] held_sel;

    // Priority pick (lowest index wins) among rising and among held directions,
    // then the next direction state.
    always_comb begin
        rise_any   = |rise[3:0];
        held_any   = |db[3:0];
        rise_sel   = 2'd0;
        held_sel   = 2'd0;
        state_next = state_reg;
        dir_next   = dir_reg;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) rise_sel = 2'(i);
            if (db[i])   held_sel = 2'(i);
        end
        if (state_reg == IDLE) begin
            if (rise_any) begin
                state_next = HOLD;
                dir_next   = rise_sel;
            end
        end else begin
            if (!held_any) begin
                state_next = IDLE;
            end else if (rise_any) begin
                // The held direction cannot rise, so rise_sel is a new one.
                dir_next = rise_sel;
            end else if (!db[dir_reg]) begin
                dir_next = held_sel;
            end
        end
    end

    // Direction FSM with registered move outputs and bomb pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            dir_reg      <= 2'b10;
            move_reg     <= 4'b0000;
            bomb_req_reg <= 1'b0;
        end else begin
            bomb_req_reg <= rise[4] & ~bus.gameover;
            if (bus.gameover) begin
                move_reg <= 4'b0000;
            end else begin
                state_reg <= state_next;
                dir_reg   <= dir_next;
                move_reg  <= (state_next == HOLD) ? (4'b0001 << dir_next) : 4'b0000;
            end
        end
    end

    assign bus.U           = move_reg[0];
    assign bus.R           = move_reg[1];
    assign bus.D           = move_reg[2];
    assign bus.L           = move_reg[3];
    assign bus.current_dir = dir_reg;
    assign bus.bomb_req    = bomb_req_reg;

endmodule

// File: tb/tb_bm_input_controller.sv
// Bench for bm_input_controller with a short debounce window.
// Every clock edge is compared against a behavioural model: a button's
// stable level flips once its sampled raw value has disagreed with it for a
// whole window, and the direction follows the newest press with U>R>D>L
// fallback. Directed scenarios add exact-latency checks on top.
module tb_bm_input_controller;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic       gameover;

    int checks   = 0;
    int failures = 0;

    bm_input_controller_if bus();

    assign bus.btn_u    = btn[0];
    assign bus.btn_r    = btn[1];
    assign bus.btn_d    = btn[2];
    assign bus.btn_l    = btn[3];
    assign bus.btn_bomb = btn[4];
    assign bus.gameover = gameover;

    bm_input_controller #(.DB_CNT(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic       m_hist [5][DB+1];   // m_hist[i][j]: raw sampled j+1 edges ago
    logic [4:0] m_db;
    logic [4:0] m_dbp;
    bit         m_active;
    logic [1:0] m_cur;
    logic [3:0] m_move;
    logic       m_bomb;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by the edge that samples the current inputs.
    task automatic model_edge();
        logic [4:0] rise;
        logic [4:0] new_db;
        bit         flip;
        if (!reset) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j <= DB; j++) m_hist[i][j] = 1'b0;
            m_db = '0; m_dbp = '0; m_active = 0; m_cur = 2'b10;
            m_move = '0; m_bomb = 1'b0;
        end else begin
            rise   = m_db & ~m_dbp;
            m_bomb = rise[4] & ~gameover;
            if (gameover) begin
                m_move = '0;
            end else begin
                if (rise[3:0] != 0) begin
                    m_active = 1;
                    m_cur    = first_set(rise[3:0]);
                end else if (m_active && m_db[3:0] == 0) begin
                    m_active = 0;
                end else if (m_active && !m_db[m_cur]) begin
                    m_cur = first_set(m_db[3:0]);
                end
                m_move = m_active ? (4'b0001 << m_cur) : 4'b0000;
            end
            for (int i = 0; i < 5; i++) begin
                flip = 1;
                for (int j = 1; j <= DB; j++) if (m_hist[i][j] == m_db[i]) flip = 0;
                new_db[i] = flip ? ~m_db[i] : m_db[i];
            end
            m_dbp = m_db;
            m_db  = new_db;
            for (int i = 0; i < 5; i++) begin
                for (int j = DB; j >= 1; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = btn[i];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("move", {4'b0, bus.L, bus.D, bus.R, bus.U}, {4'b0, m_move});
        check("dir", {6'b0, bus.current_dir}, {6'b0, m_cur});
        check("bomb", {7'b0, bus.bomb_req}, {7'b0, m_bomb});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [7:0] moves();
        return {4'b0, bus.L, bus.D, bus.R, bus.U};
    endfunction

    initial begin
        int pulses;
        reset = 1'b0; btn = '0; gameover = 1'b0;

        // Reset state
        steps(2);
        check("rst_move", moves(), 8'h00);
        check("rst_dir", {6'b0, bus.current_dir}, 8'h02);
        check("rst_bomb", {7'b0, bus.bomb_req}, 8'h00);
        $display("reset: move=%b dir=%b", moves(), bus.current_dir);
        reset = 1'b1;
        steps(2);

        // Right press: output exactly on the 7th edge
        btn[1] = 1'b1;
        steps(6);
        check("t1_R_early", {7'b0, bus.R}, 8'h00);
        step();
        check("t1_move", moves(), 8'h02);
        check("t1_dir", {6'b0, bus.current_dir}, 8'h01);
        $display("press R: move=%b dir=%b", moves(), bus.current_dir);
        btn[1] = 1'b0;
        steps(8);

        // Short glitch is ignored, a 5-cycle pulse is accepted
        btn[0] = 1'b1;
        steps(3);
        btn[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t2_glitch", {7'b0, bus.U}, 8'h00);
        end
        btn[0] = 1'b1;
        steps(5);
        btn[0] = 1'b0;
        steps(2);
        check("t2_U_on", {7'b0, bus.U}, 8'h01);
        steps(4);
        check("t2_U_still", {7'b0, bus.U}, 8'h01);
        step();
        check("t2_U_off", {7'b0, bus.U}, 8'h00);
        $display("pulse U: move=%b dir=%b", moves(), bus.current_dir);
        steps(4);

        // Newest press wins, release falls back, release all keeps dir
        btn[1] = 1'b1; steps(7);
        btn[2] = 1'b1; steps(7);
        check("t3_D", moves(), 8'h04);
        check("t3_D_dir", {6'b0, bus.current_dir}, 8'h02);
        btn[2] = 1'b0; steps(7);
        check("t3_R", moves(), 8'h02);
        check("t3_R_dir", {6'b0, bus.current_dir}, 8'h01);
        btn[1] = 1'b0; steps(7);
        check("t3_none", moves(), 8'h00);
        check("t3_keep_dir", {6'b0, bus.current_dir}, 8'h01);
        $display("R then D: move=%b dir=%b", moves(), bus.current_dir);

        // Simultaneous U and L rise
        btn[0] = 1'b1; btn[3] = 1'b1; steps(7);
        check("t4_U", moves(), 8'h01);
        check("t4_dir", {6'b0, bus.current_dir}, 8'h00);
        $display("U+L: move=%b dir=%b", moves(), bus.current_dir);
        btn[0] = 1'b0; btn[3] = 1'b0; steps(8);

        // Bomb: one pulse per press, none under gameover
        btn[4] = 1'b1; pulses = 0;
        for (int k = 0; k < 20; k++) begin step(); pulses += int'(bus.bomb_req); end
        check("t5_one_pulse", 8'(pulses), 8'h01);
        btn[4] = 1'b0; steps(8);
        gameover = 1'b1; btn[4] = 1'b1; pulses = 0;
        for (int k = 0; k < 20; k++) begin step(); pulses += int'(bus.bomb_req); end
        check("t5_no_pulse", 8'(pulses), 8'h00);
        btn[4] = 1'b0; steps(8);
        gameover = 1'b0; steps(2);
        $display("bomb: pulses under gameover=%0d", pulses);

        // Gameover freeze/resume and reset mid-hold
        btn[3] = 1'b1; steps(7);
        check("t6_L", moves(), 8'h08);
        gameover = 1'b1; step();
        check("t6_go_move", moves(), 8'h00);
        check("t6_go_dir", {6'b0, bus.current_dir}, 8'h03);
        gameover = 1'b0; step();
        check("t6_resume", moves(), 8'h08);
        reset = 1'b0; step();
        check("t6_rst_move", moves(), 8'h00);
        check("t6_rst_dir", {6'b0, bus.current_dir}, 8'h02);
        reset = 1'b1; steps(7);
        check("t6_reaccept", moves(), 8'h08);
        $display("gameover/reset: move=%b dir=%b", moves(), bus.current_dir);
        btn[3] = 1'b0; steps(8);

        // Randomised activity against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 5; i++) if ($urandom_range(7) == 0) btn[i] = ~btn[i];
            if ($urandom_range(63) == 0) gameover = ~gameover;
            reset = ($urandom_range(499) != 0);
            step();
        end
        $display("random: %0d edges compared", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
